fp_mult_sched: RTL
==================

FP_MULT_SCHED -- requirements
Module: fp_mult_sched

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters sharing one fp_mult_top.
REQ-002 Parameter LATENCY, default 3, SHALL set the fp_mult_top input-to-z latency in clock cycles.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 req_valid  input  NREQ  SHALL flag, per requester, a pending multiply.
REQ-006 req_ready  output  NREQ  SHALL be the one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-007 req_a, req_b  input  NREQ x 32  SHALL carry IEEE-754 single operands per requester.
REQ-008 req_rnd  input  NREQ x 3  SHALL carry the rounding mode per requester: 000 near-even, 001 zero, 010 +inf, 011 -inf, 100 near-up, 101 away-zero.
REQ-009 rsp_valid  output  1  SHALL pulse for one cycle per completed result.
REQ-010 rsp_id  output  clog2(NREQ)  SHALL give the requester index owning the result.
REQ-011 rsp_z  output  32 and rsp_status  output  8  SHALL carry fp_mult_top z and status for the result.
REQ-012 drain  input  1  SHALL request that issuing stop and the pipeline empty.
REQ-013 drained  output  1  SHALL indicate that the block is in DRAINED.
REQ-014 busy  output  1  SHALL indicate that at least one operation is in flight.

Function
REQ-015 Arbitration SHALL be round-robin: grant the lowest requester index >= ptr with req_valid high, wrapping modulo NREQ; at most one grant per cycle.
REQ-016 After each transfer, ptr SHALL become (granted index + 1) mod NREQ; ptr SHALL be unchanged when no transfer occurs.
REQ-017 req_ready SHALL be combinational from req_valid, ptr, state and drain, and SHALL be all-zero unless the state is RUN and drain is low.
REQ-018 On a transfer, the operands, rnd and id SHALL be registered into an issue stage that drives fp_mult_top on the next cycle.
REQ-019 rnd values 110 and 111 SHALL be issued as 000.
REQ-020 id SHALL travel through a LATENCY-deep valid/id shift register aligned with fp_mult_top.
REQ-021 rsp_valid SHALL assert exactly LATENCY+1 cycles after the transfer edge.
REQ-022 rsp_z, rsp_status and rsp_id SHALL be valid only while rsp_valid is high; they SHALL hold their last value otherwise.
REQ-023 Responses SHALL arrive in issue order, with no backpressure, and throughput SHALL be one result per cycle.
REQ-024 An in-flight counter (0..LATENCY+1) SHALL increment on transfer and decrement on rsp_valid; when both occur in the same cycle it SHALL be unchanged.
REQ-025 busy SHALL equal (counter != 0).
REQ-026 State machine transitions SHALL be:
- RUN -> DRAIN when drain is high.
- DRAIN -> DRAINED when the counter is 0.
- DRAIN -> RUN when drain falls before the counter reaches 0.
- DRAINED -> RUN when drain is low.
REQ-027 drain asserted in the same cycle as req_valid SHALL block that transfer.

Reset
REQ-028 While rst is high, the block SHALL force state RUN, ptr 0, counter 0, all valid bits 0, req_ready 0, rsp_valid 0, rsp_id 0, rsp_z 0, rsp_status 0, drained 0 and busy 0.
REQ-029 fp_mult_top SHALL receive ~rst on its active-low reset port.
REQ-030 A reset asserted mid-operation SHALL discard all in-flight operations; no rsp_valid SHALL follow for them.

Structure
REQ-031 Package fp_mult_pkg SHALL hold NREQ, LATENCY, rnd_t (the six rounding encodings) and sched_state_t (RUN, DRAIN, DRAINED).
REQ-032 The round-robin grant logic SHALL be a sub-module named rr_arbiter.
REQ-033 fp_mult_top SHALL be instantiated once, unmodified.

Verification
REQ-034 Single request: req0 with a=3F800000, b=40000000, rnd=000 -> rsp_valid 4 cycles after the transfer, rsp_id=0, rsp_z=40000000.
REQ-035 All four req_valid held high for 8 cycles -> grants in order 0,1,2,3,0,1,2,3 and back-to-back responses with matching rsp_id order.
REQ-036 req2 with a=3F800000, b=BF800000, rnd=011 while ptr=3 -> wrap grant to 2, rsp_id=2, rsp_z=BF800000.
REQ-037 drain raised with 3 operations in flight -> req_ready=0 at once; 3 responses follow; drained=1 next cycle; drain low -> RUN and grants resume.
REQ-038 rst pulsed for 1 cycle with 2 operations in flight -> no rsp_valid afterwards, busy=0, and the next grant goes to req0.
REQ-039 req1 with rnd=111, a=3F800001, b=3F800001 -> rsp_z equals the rnd=000 result (3F800002).

Source files
------------

// File: rtl/fp_mult_pkg.sv
// Shared types and defaults for the shared fp multiplier scheduler.
package fp_mult_pkg;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned LATENCY = 3;
  localparam int unsigned FP_W    = 32;
  localparam int unsigned RND_W   = 3;
  localparam int unsigned STAT_W  = 8;

  typedef enum logic [RND_W-1:0] {
    RND_NE   = 3'b000,
    RND_ZERO = 3'b001,
    RND_PINF = 3'b010,
    RND_NINF = 3'b011,
    RND_UP   = 3'b100,
    RND_AWAY = 3'b101
  } rnd_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DRAINED = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
    rnd_t            rnd;
  } mul_op_t;

  // Reserved encodings fall back to round-to-nearest-even.
  function automatic rnd_t rnd_sanitize(input logic [RND_W-1:0] r);
    return (r > 3'd5) ? RND_NE : rnd_t'(r);
  endfunction

endpackage

// File: rtl/fp_mult_top.sv
// IEEE-754 single multiplier, LATENCY register stages from inputs to z.
// Subnormal operands and results are flushed to zero.
module fp_mult_top #(
  parameter int unsigned LATENCY = fp_mult_pkg::LATENCY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  rnd,
  output logic [31:0] z,
  output logic [7:0]  status
);

  logic                     sign, inc, inexact, ovf_inf;
  logic                     a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic                     rbit, sbit;
  logic [47:0]              prod;
  logic [23:0]              mant;
  logic [24:0]              mrnd;
  logic [22:0]              frac;
  logic signed [9:0]        exp_s, exp_f;
  logic [31:0]              z_c;
  logic [7:0]               st_c;
  logic [LATENCY-1:0][31:0] z_q, z_d;
  logic [LATENCY-1:0][7:0]  st_q, st_d;

  always_comb begin
    sign   = a[31] ^ b[31];
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    prod   = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    exp_s  = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    mant   = prod[46:23];
    rbit   = prod[22];
    sbit   = |prod[21:0];
    if (prod[47]) begin
      mant  = prod[47:24];
      rbit  = prod[23];
      sbit  = |prod[22:0];
      exp_s = exp_s + 10'sd1;
    end
    inexact = rbit | sbit;

    case (rnd)
      fp_mult_pkg::RND_ZERO: inc = 1'b0;
      fp_mult_pkg::RND_PINF: inc = !sign & inexact;
      fp_mult_pkg::RND_NINF: inc = sign & inexact;
      fp_mult_pkg::RND_UP:   inc = rbit & (sbit | !sign);
      fp_mult_pkg::RND_AWAY: inc = rbit;
      default:               inc = rbit & (sbit | mant[0]);
    endcase

    // A mantissa carry only happens from all-ones, leaving a zero fraction.
    mrnd  = {1'b0, mant} + 25'(inc);
    frac  = mrnd[24] ? mrnd[23:1] : mrnd[22:0];
    exp_f = exp_s + (mrnd[24] ? 10'sd1 : 10'sd0);

    case (rnd)
      fp_mult_pkg::RND_ZERO: ovf_inf = 1'b0;
      fp_mult_pkg::RND_PINF: ovf_inf = !sign;
      fp_mult_pkg::RND_NINF: ovf_inf = sign;
      default:               ovf_inf = 1'b1;
    endcase

    // status: [0] zero [1] inf [2] invalid [3] tiny [4] huge [5] inexact
    z_c  = {sign, exp_f[7:0], frac};
    st_c = {2'b00, inexact, 5'b00000};
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      z_c  = 32'h7FC0_0000;
      st_c = 8'b0000_0100;
    end else if (a_inf || b_inf) begin
      z_c  = {sign, 8'hFF, 23'd0};
      st_c = 8'b0000_0010;
    end else if (a_zero || b_zero) begin
      z_c  = {sign, 31'd0};
      st_c = 8'b0000_0001;
    end else if (exp_f >= 10'sd255) begin
      z_c  = ovf_inf ? {sign, 8'hFF, 23'd0} : {sign, 8'hFE, 23'h7F_FFFF};
      st_c = {2'b00, 1'b1, 1'b1, 2'b00, ovf_inf, 1'b0};
    end else if (exp_f <= 10'sd0) begin
      z_c  = {sign, 31'd0};
      st_c = 8'b0010_1001;
    end
  end

  always_comb begin
    z_d  = (LATENCY*32)'({z_q, z_c});
    st_d = (LATENCY*8)'({st_q, st_c});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q  <= '0;
      st_q <= '0;
    end else begin
      z_q  <= z_d;
      st_q <= st_d;
    end
  end

  assign z      = z_q[LATENCY-1];
  assign status = st_q[LATENCY-1];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant: lowest index at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          en,
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_c,
  output logic [IW-1:0] gnt_idx_c,
  output logic          gnt_vld_c
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_c     = '0;
    gnt_idx_c = '0;
    gnt_vld_c = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'((32'(ptr) + k) % N);
      if (en && !gnt_vld_c && req[cand]) begin
        gnt_c[cand] = 1'b1;
        gnt_idx_c   = cand;
        gnt_vld_c   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_mult_sched.sv
// Shares one fp_mult_top among NREQ requesters with round-robin issue,
// id tracking alongside the multiplier pipeline, and a drain handshake.
module fp_mult_sched #(
  parameter  int unsigned NREQ    = fp_mult_pkg::NREQ,
  parameter  int unsigned LATENCY = fp_mult_pkg::LATENCY,
  localparam int unsigned IW      = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int unsigned CW      = $clog2(LATENCY + 2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0][31:0] req_a,
  input  logic [NREQ-1:0][31:0] req_b,
  input  logic [NREQ-1:0][2:0]  req_rnd,
  output logic                  rsp_valid,
  output logic [IW-1:0]         rsp_id,
  output logic [31:0]           rsp_z,
  output logic [7:0]            rsp_status,
  input  logic                  drain,
  output logic                  drained,
  output logic                  busy
);

  fp_mult_pkg::sched_state_t state_q, state_d;
  fp_mult_pkg::mul_op_t      iss_q, iss_d;
  logic [IW-1:0]             ptr_q, ptr_d, iss_id_q, iss_id_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      iss_vld_q, iss_vld_d;
  logic [LATENCY-1:0]        vld_q, vld_d;
  logic [LATENCY-1:0][IW-1:0] id_q, id_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [IW-1:0]             rsp_id_q, rsp_id_d;
  logic [31:0]               rsp_z_q, rsp_z_d;
  logic [7:0]                rsp_status_q, rsp_status_d;
  logic                      drained_q, drained_d, busy_q, busy_d;

  logic                      arb_en_c, xfer_c;
  logic [IW-1:0]             gnt_idx_c;
  logic [31:0]               mul_z;
  logic [7:0]                mul_status;

  assign arb_en_c = !rst && (state_q == fp_mult_pkg::RUN) && !drain;

  rr_arbiter #(.N(NREQ)) u_arb (
    .en        (arb_en_c),
    .req       (req_valid),
    .ptr       (ptr_q),
    .gnt_c     (req_ready),
    .gnt_idx_c (gnt_idx_c),
    .gnt_vld_c (xfer_c)
  );

  fp_mult_top #(.LATENCY(LATENCY)) u_mult (
    .clk    (clk),
    .rst_n  (~rst),
    .a      (iss_q.a),
    .b      (iss_q.b),
    .rnd    (iss_q.rnd),
    .z      (mul_z),
    .status (mul_status)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    iss_d        = iss_q;
    iss_id_d     = iss_id_q;
    iss_vld_d    = xfer_c;
    vld_d        = LATENCY'({vld_q, iss_vld_q});
    id_d         = (LATENCY*IW)'({id_q, iss_id_q});
    rsp_valid_d  = vld_q[LATENCY-1];
    rsp_id_d     = rsp_id_q;
    rsp_z_d      = rsp_z_q;
    rsp_status_d = rsp_status_q;

    if (xfer_c) begin
      ptr_d     = IW'((32'(gnt_idx_c) + 32'd1) % NREQ);
      iss_d.a   = req_a[gnt_idx_c];
      iss_d.b   = req_b[gnt_idx_c];
      iss_d.rnd = fp_mult_pkg::rnd_sanitize(req_rnd[gnt_idx_c]);
      iss_id_d  = gnt_idx_c;
    end

    if (rsp_valid_d) begin
      rsp_id_d     = id_q[LATENCY-1];
      rsp_z_d      = mul_z;
      rsp_status_d = mul_status;
    end

    // Retire on the edge that raises rsp_valid so the count stays <= LATENCY+1.
    case ({xfer_c, rsp_valid_d})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    case (state_q)
      fp_mult_pkg::RUN:     if (drain) state_d = fp_mult_pkg::DRAIN;
      fp_mult_pkg::DRAIN: begin
        if (cnt_q == '0)  state_d = fp_mult_pkg::DRAINED;
        else if (!drain)  state_d = fp_mult_pkg::RUN;
      end
      fp_mult_pkg::DRAINED: if (!drain) state_d = fp_mult_pkg::RUN;
      default:              state_d = fp_mult_pkg::RUN;
    endcase

    drained_d = (state_d == fp_mult_pkg::DRAINED);
    busy_d    = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= fp_mult_pkg::RUN;
      ptr_q        <= '0;
      cnt_q        <= '0;
      iss_q        <= '0;
      iss_id_q     <= '0;
      iss_vld_q    <= 1'b0;
      vld_q        <= '0;
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_z_q      <= '0;
      rsp_status_q <= '0;
      drained_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      iss_q        <= iss_d;
      iss_id_q     <= iss_id_d;
      iss_vld_q    <= iss_vld_d;
      vld_q        <= vld_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_z_q      <= rsp_z_d;
      rsp_status_q <= rsp_status_d;
      drained_q    <= drained_d;
      busy_q       <= busy_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_z      = rsp_z_q;
  assign rsp_status = rsp_status_q;
  assign drained    = drained_q;
  assign busy       = busy_q;

endmodule
